// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the two-requester register-file arbiter:
//   - default register data width and register index width
//   - ownership state enumeration used by the arbiter FSM
//   - a helper that maps a requester index to its ownership state
// -----------------------------------------------------------------------------
package regfile_pkg;

  // 16 registers of 18 bits each by default.
  localparam int DATA_W_DEFAULT = 18;
  localparam int ADDR_W_DEFAULT = 4;

  // SHARED : both requesters compete, round-robin breaks ties.
  // OWN0/1 : the named requester holds the register file exclusively.
  typedef enum logic [1:0] {
    SHARED = 2'd0,
    OWN0   = 2'd1,
    OWN1   = 2'd2
  } arb_state_e;

  // Ownership state taken when requester idx is granted with lock set.
  function automatic arb_state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage : regfile_pkg

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
//
// Two-way round-robin picker. Grants a lone requester directly; when both
// request, the pointer decides. After any grant taken while update is high,
// the pointer moves to the requester that did not win.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset (pointer -> requester 0)
//   req     in   [1:0] request vector, bit i = requester i
//   update  in   allow the pointer to advance on this cycle's grant
//   grant   out  [1:0] one-hot (or zero) grant vector, combinational
// -----------------------------------------------------------------------------
module arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 0 = requester 0 wins a tie, 1 = requester 1 wins a tie.
  logic ptr;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Granting requester 0 hands priority to 1 and vice versa, so the new
  // pointer value is simply grant[0].
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule : arb_rr2

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Shares one external register file (one write port, two read ports) between
// two requesters. At most one operation is granted per cycle. A grant with
// lock set gives the winner exclusive ownership until it issues an unlocked
// operation. Reads return one cycle after the grant; the read data comes
// straight from the register file's read ports.
//
// Ports (i = 0, 1):
//   clock, reset            rising-edge clock, async active-high reset
//   req_valid_i             operation offered by requester i
//   req_ready_i             requester i granted this cycle (combinational)
//   req_write_i             1 = write, 0 = read
//   req_lock_i              keep ownership after this grant
//   req_addr_a_i            write index / read index 1
//   req_addr_b_i            read index 2
//   req_wdata_i             write data
//   rsp_valid_i             read result valid (cycle after the read grant)
//   rsp_data_a_i/_b_i       read results (rf_data_to_read1/2 passed through)
//   rf_enable, rf_load      register-file strobe, 1 = write
//   rf_reg_to_write         write index
//   rf_reg_to_read1/2       read indices
//   rf_data_to_write        write data
//   rf_data_to_read1/2      read data from the register file
// -----------------------------------------------------------------------------
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,

  // Requester 0
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_write_0,
  input  logic              req_lock_0,
  input  logic [ADDR_W-1:0] req_addr_a_0,
  input  logic [ADDR_W-1:0] req_addr_b_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_data_a_0,
  output logic [DATA_W-1:0] rsp_data_b_0,

  // Requester 1
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_write_1,
  input  logic              req_lock_1,
  input  logic [ADDR_W-1:0] req_addr_a_1,
  input  logic [ADDR_W-1:0] req_addr_b_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_a_1,
  output logic [DATA_W-1:0] rsp_data_b_1,

  // Register file
  output logic              rf_enable,
  output logic              rf_load,
  output logic [ADDR_W-1:0] rf_reg_to_write,
  output logic [ADDR_W-1:0] rf_reg_to_read1,
  output logic [ADDR_W-1:0] rf_reg_to_read2,
  output logic [DATA_W-1:0] rf_data_to_write,
  input  logic [DATA_W-1:0] rf_data_to_read1,
  input  logic [DATA_W-1:0] rf_data_to_read2
);

  arb_state_e state;
  arb_state_e state_next;

  logic [1:0] valid_vec;
  logic [1:0] write_vec;
  logic [1:0] lock_vec;
  logic [1:0] arb_req;
  logic [1:0] arb_grant;
  logic [1:0] grant;
  logic       active;
  logic       sel;
  logic [1:0] rsp_pending;

  assign valid_vec = {req_valid_1, req_valid_0};
  assign write_vec = {req_write_1, req_write_0};
  assign lock_vec  = {req_lock_1,  req_lock_0};

  // The round-robin picker only sees requests while the file is shared, and
  // only advances its pointer on grants made in that state.
  assign arb_req = (state == SHARED) ? valid_vec : 2'b00;

  arb_rr2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (arb_req),
    .update (state == SHARED),
    .grant  (arb_grant)
  );

  // Final grant. Reset blocks every grant combinationally so ready and the
  // rf strobes read 0 for the whole time reset is high. An owner that goes
  // idle still excludes the other requester.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (state)
        SHARED:  grant = arb_grant;
        OWN0:    grant = {1'b0, valid_vec[0]};
        OWN1:    grant = {valid_vec[1], 1'b0};
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  // Ownership FSM: a locked grant in SHARED takes ownership; an unlocked
  // grant by the owner gives it back.
  always_comb begin
    state_next = state;
    unique case (state)
      SHARED: begin
        if ((grant & lock_vec) != 2'b00) begin
          state_next = own_state(grant[1]);
        end
      end
      OWN0: begin
        if (grant[0] && !lock_vec[0]) begin
          state_next = SHARED;
        end
      end
      OWN1: begin
        if (grant[1] && !lock_vec[1]) begin
          state_next = SHARED;
        end
      end
      default: state_next = SHARED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SHARED;
    end else begin
      state <= state_next;
    end
  end

  // Register-file command: the granted requester's fields, or all zeros.
  assign active = grant != 2'b00;
  assign sel    = grant[1];

  always_comb begin
    rf_enable        = 1'b0;
    rf_load          = 1'b0;
    rf_reg_to_write  = '0;
    rf_reg_to_read1  = '0;
    rf_reg_to_read2  = '0;
    rf_data_to_write = '0;
    if (active) begin
      rf_enable        = 1'b1;
      rf_load          = write_vec[sel];
      rf_reg_to_write  = sel ? req_addr_a_1 : req_addr_a_0;
      rf_reg_to_read1  = sel ? req_addr_a_1 : req_addr_a_0;
      rf_reg_to_read2  = sel ? req_addr_b_1 : req_addr_b_0;
      rf_data_to_write = sel ? req_wdata_1  : req_wdata_0;
    end
  end

  // Response pipeline: one flag per requester, set for exactly the cycle
  // after a granted read. Reset drops any response still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_pending <= 2'b00;
    end else begin
      rsp_pending <= grant & ~write_vec;
    end
  end

  assign rsp_valid_0 = rsp_pending[0];
  assign rsp_valid_1 = rsp_pending[1];

  // The register file registers its read ports, so its outputs already line
  // up with the response cycle; both requesters see the same data and only
  // rsp_valid tells them whose it is.
  assign rsp_data_a_0 = rf_data_to_read1;
  assign rsp_data_b_0 = rf_data_to_read2;
  assign rsp_data_a_1 = rf_data_to_read1;
  assign rsp_data_b_1 = rf_data_to_read2;

endmodule : regfile_arbiter

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Drives regfile_arbiter with directed scenarios and random traffic. A small
// synchronous register file sits on the rf_* ports. Expected grants,
// responses and rf commands come from a reference model that tracks the
// owner, the tie-break priority and the register contents.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int DW = 18;
  localparam int AW = 4;
  localparam int RFW = 2 + 3 * AW + DW;

  logic clock = 1'b0;
  logic reset;

  logic [1:0]    valid, write, lock;
  logic [AW-1:0] addr_a [2];
  logic [AW-1:0] addr_b [2];
  logic [DW-1:0] wdata  [2];

  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_data_a_0, rsp_data_b_0, rsp_data_a_1, rsp_data_b_1;
  logic          rf_enable, rf_load;
  logic [AW-1:0] rf_reg_to_write, rf_reg_to_read1, rf_reg_to_read2;
  logic [DW-1:0] rf_data_to_write, rf_data_to_read1, rf_data_to_read2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid_0      (valid[0]),
    .req_ready_0      (req_ready_0),
    .req_write_0      (write[0]),
    .req_lock_0       (lock[0]),
    .req_addr_a_0     (addr_a[0]),
    .req_addr_b_0     (addr_b[0]),
    .req_wdata_0      (wdata[0]),
    .rsp_valid_0      (rsp_valid_0),
    .rsp_data_a_0     (rsp_data_a_0),
    .rsp_data_b_0     (rsp_data_b_0),
    .req_valid_1      (valid[1]),
    .req_ready_1      (req_ready_1),
    .req_write_1      (write[1]),
    .req_lock_1       (lock[1]),
    .req_addr_a_1     (addr_a[1]),
    .req_addr_b_1     (addr_b[1]),
    .req_wdata_1      (wdata[1]),
    .rsp_valid_1      (rsp_valid_1),
    .rsp_data_a_1     (rsp_data_a_1),
    .rsp_data_b_1     (rsp_data_b_1),
    .rf_enable        (rf_enable),
    .rf_load          (rf_load),
    .rf_reg_to_write  (rf_reg_to_write),
    .rf_reg_to_read1  (rf_reg_to_read1),
    .rf_reg_to_read2  (rf_reg_to_read2),
    .rf_data_to_write (rf_data_to_write),
    .rf_data_to_read1 (rf_data_to_read1),
    .rf_data_to_read2 (rf_data_to_read2)
  );

  // Environment: synchronous register file with registered read ports.
  logic [DW-1:0] rf_mem [16];
  always @(posedge clock) begin
    if (rf_enable) begin
      if (rf_load) rf_mem[rf_reg_to_write] <= rf_data_to_write;
      else begin
        rf_data_to_read1 <= rf_mem[rf_reg_to_read1];
        rf_data_to_read2 <= rf_mem[rf_reg_to_read2];
      end
    end
  end

  // ---------------- reference model ----------------
  int            m_owner;   // -1 = shared, else owning requester
  int            m_prio;    // requester that wins a tie
  int            m_pend;    // -1 = no response due, else requester
  logic [DW-1:0] m_pend_a, m_pend_b;
  logic [DW-1:0] m_mem [16];

  function automatic void model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_pend  = -1;
  endfunction

  function automatic int model_grant();
    if (m_owner >= 0) return valid[m_owner] ? m_owner : -1;
    if (valid == 2'b11) return m_prio;
    if (valid[0]) return 0;
    if (valid[1]) return 1;
    return -1;
  endfunction

  function automatic void model_commit(input int g);
    m_pend = -1;
    if (g < 0) return;
    if (write[g]) m_mem[addr_a[g]] = wdata[g];
    else begin
      m_pend   = g;
      m_pend_a = m_mem[addr_a[g]];
      m_pend_b = m_mem[addr_b[g]];
    end
    if (m_owner < 0) begin
      m_prio = 1 - g;
      if (lock[g]) m_owner = g;
    end else if (!lock[g]) begin
      m_owner = -1;
    end
  endfunction

  function automatic int grant_of(input logic [1:0] r);
    case (r)
      2'b00:   return -1;
      2'b01:   return 0;
      2'b10:   return 1;
      default: return 9;
    endcase
  endfunction

  // ---------------- per-cycle observation ----------------
  int             obs_grant, exp_grant;
  logic [1:0]     obs_rsp, exp_rsp;
  logic [DW-1:0]  obs_a, obs_b, exp_a, exp_b;
  logic [RFW-1:0] obs_rf, exp_rf;

  // Called just after a negedge with inputs applied. Samples DUT outputs,
  // builds the expected values, then advances one clock and the model.
  task automatic run_cycle();
    #1;
    exp_grant = model_grant();
    obs_grant = grant_of({req_ready_1, req_ready_0});
    exp_rsp   = (m_pend == 0) ? 2'b01 : (m_pend == 1) ? 2'b10 : 2'b00;
    obs_rsp   = {rsp_valid_1, rsp_valid_0};
    exp_a     = m_pend_a;
    exp_b     = m_pend_b;
    obs_a     = (m_pend == 1) ? rsp_data_a_1 : rsp_data_a_0;
    obs_b     = (m_pend == 1) ? rsp_data_b_1 : rsp_data_b_0;
    obs_rf    = {rf_enable, rf_load, rf_reg_to_write, rf_reg_to_read1,
                 rf_reg_to_read2, rf_data_to_write};
    if (exp_grant >= 0)
      exp_rf = {1'b1, write[exp_grant], addr_a[exp_grant], addr_a[exp_grant],
                addr_b[exp_grant], wdata[exp_grant]};
    else
      exp_rf = '0;
    @(posedge clock);
    model_commit(exp_grant);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    valid = 2'b00; write = 2'b00; lock = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_a[i] = '0; addr_b[i] = '0; wdata[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic lk,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d);
    valid[i] = 1'b1; write[i] = w; lock[i] = lk;
    addr_a[i] = a; addr_b[i] = b; wdata[i] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs: ready/rsp got %b%b/%b%b want 00/00",
                 req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0);
      end
      n_cmp++;
      if ({rf_enable, rf_load, rf_reg_to_write, rf_reg_to_read1, rf_reg_to_read2,
           rf_data_to_write} !== '0) begin
        n_fail++;
        $display("FAIL reset_rf: rf_enable=%b rf_load=%b want all rf outputs 0",
                 rf_enable, rf_load);
      end
      @(posedge clock);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    set_req(0, 1'b0, 1'b0, 4'd0, 4'd0, '0);
    set_req(1, 1'b0, 1'b0, 4'd0, 4'd0, '0);
    run_cycle();
    n_cmp++;
    if (obs_grant !== 0) begin
      n_fail++;
      $display("FAIL reset_first_pick: got %0d want 0", obs_grant);
    end
    idle_inputs();
    run_cycle();
  endtask

  // Load every register through requester 0 so later reads are defined.
  task automatic preload();
    for (int r = 0; r < 16; r++) begin
      idle_inputs();
      set_req(0, 1'b1, 1'b0, AW'(r), 4'd0, DW'($urandom));
      run_cycle();
      n_cmp++;
      if (obs_grant !== exp_grant || obs_rf !== exp_rf) begin
        n_fail++;
        $display("FAIL preload r%0d: grant %0d rf %h want %0d %h",
                 r, obs_grant, obs_rf, exp_grant, exp_rf);
      end
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_write_read();
    idle_inputs();
    set_req(0, 1'b1, 1'b0, 4'd3, 4'd0, 18'h2A5A5);
    run_cycle();
    set_req(0, 1'b0, 1'b0, 4'd3, 4'd3, '0);
    run_cycle();
    n_cmp++;
    if (obs_grant !== 0) begin
      n_fail++;
      $display("FAIL wr_rd_grant: got %0d want 0", obs_grant);
    end
    idle_inputs();
    run_cycle();
    n_cmp++;
    if (obs_rsp !== 2'b01 || obs_a !== 18'h2A5A5 || obs_b !== 18'h2A5A5) begin
      n_fail++;
      $display("FAIL wr_rd_rsp: valid %b a %h b %h want 01 2a5a5 2a5a5",
               obs_rsp, obs_a, obs_b);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'd1, 4'd2, '0);
    set_req(1, 1'b0, 1'b0, 4'd4, 4'd7, '0);
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      n_cmp++;
      if (obs_grant !== (i % 2)) begin
        n_fail++;
        $display("FAIL rr_grant cycle %0d: got %0d want %0d", i, obs_grant, i % 2);
      end
      n_cmp++;
      if (obs_rsp !== exp_rsp || (exp_rsp != 2'b00 && (obs_a !== exp_a || obs_b !== exp_b))) begin
        n_fail++;
        $display("FAIL rr_rsp cycle %0d: valid %b a %h b %h want %b %h %h",
                 i, obs_rsp, obs_a, obs_b, exp_rsp, exp_a, exp_b);
      end
    end
    idle_inputs();
    run_cycle();
    n_cmp++;
    if (obs_rsp !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_last_rsp: got %b want 10", obs_rsp);
    end
  endtask

  task automatic test_lock();
    int want [5] = '{1, 1, 1, 1, 0};
    do_reset();
    set_req(0, 1'b0, 1'b0, 4'd2, 4'd3, '0);
    run_cycle();                         // lone 0 wins, priority moves to 1
    for (int i = 0; i < 5; i++) begin
      set_req(1, 1'b1, (i < 3), AW'(8 + i), 4'd0, DW'(i + 100));
      run_cycle();
      n_cmp++;
      if (obs_grant !== want[i] || obs_grant !== exp_grant) begin
        n_fail++;
        $display("FAIL lock_seq step %0d: got %0d want %0d", i, obs_grant, want[i]);
      end
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_own_idle();
    do_reset();
    set_req(0, 1'b0, 1'b1, 4'd5, 4'd6, '0);
    run_cycle();                         // OWN0, priority now 1
    valid[0] = 1'b0;
    set_req(1, 1'b0, 1'b0, 4'd1, 4'd1, '0);
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      n_cmp++;
      if (req_ready_1 !== 1'b0 || obs_grant !== -1 || obs_rf !== '0) begin
        n_fail++;
        $display("FAIL own_idle cycle %0d: grant %0d rf %h want -1 0", i, obs_grant, obs_rf);
      end
    end
    set_req(0, 1'b0, 1'b0, 4'd5, 4'd6, '0);
    run_cycle();
    n_cmp++;
    if (obs_grant !== 0) begin
      n_fail++;
      $display("FAIL own_release: got %0d want 0", obs_grant);
    end
    run_cycle();
    n_cmp++;
    if (obs_grant !== 1) begin
      n_fail++;
      $display("FAIL own_prio_kept: got %0d want 1", obs_grant);
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic reset_after_read(input logic lk);
    idle_inputs();
    set_req(0, 1'b0, lk, 4'd3, 4'd5, '0);
    run_cycle();
    reset = 1'b1;                        // response would be visible now
    #1;
    n_cmp++;
    if ({rsp_valid_1, rsp_valid_0} !== 2'b00 || {req_ready_1, req_ready_0} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset lock=%b: rsp %b%b ready %b%b want 00 00",
               lk, rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle_inputs();
    run_cycle();
    n_cmp++;
    if (obs_rsp !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_rsp lock=%b: got %b want 00", lk, obs_rsp);
    end
  endtask

  task automatic test_reset_mid();
    reset_after_read(1'b1);              // ownership must be gone
    set_req(1, 1'b0, 1'b0, 4'd2, 4'd2, '0);
    run_cycle();
    n_cmp++;
    if (obs_grant !== 1) begin
      n_fail++;
      $display("FAIL reset_drops_owner: got %0d want 1", obs_grant);
    end
    reset_after_read(1'b0);              // priority must be back on 0
    set_req(0, 1'b0, 1'b0, 4'd2, 4'd2, '0);
    set_req(1, 1'b0, 1'b0, 4'd2, 4'd2, '0);
    run_cycle();
    n_cmp++;
    if (obs_grant !== 0) begin
      n_fail++;
      $display("FAIL reset_prio: got %0d want 0", obs_grant);
    end
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    set_req(1, 1'b1, 1'b0, 4'd5, 4'd0, 18'd1);
    run_cycle();
    set_req(1, 1'b0, 1'b0, 4'd5, 4'd5, '0);
    run_cycle();
    idle_inputs();
    run_cycle();
    n_cmp++;
    if (obs_rsp !== 2'b10 || obs_a !== 18'd1 || obs_b !== 18'd1) begin
      n_fail++;
      $display("FAIL wr_then_rd: valid %b a %h b %h want 10 1 1", obs_rsp, obs_a, obs_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i]  = ($urandom_range(0, 3) != 0);
        write[i]  = $urandom_range(0, 1);
        lock[i]   = ($urandom_range(0, 3) == 0);
        addr_a[i] = AW'($urandom);
        addr_b[i] = AW'($urandom);
        wdata[i]  = DW'($urandom);
      end
      run_cycle();
      n_cmp++;
      if (obs_grant !== exp_grant || obs_rf !== exp_rf) begin
        n_fail++;
        $display("FAIL rand_cmd cycle %0d: grant %0d rf %h want %0d %h",
                 c, obs_grant, obs_rf, exp_grant, exp_rf);
      end
      n_cmp++;
      if (obs_rsp !== exp_rsp || (exp_rsp != 2'b00 && (obs_a !== exp_a || obs_b !== exp_b))) begin
        n_fail++;
        $display("FAIL rand_rsp cycle %0d: valid %b a %h b %h want %b %h %h",
                 c, obs_rsp, obs_a, obs_b, exp_rsp, exp_a, exp_b);
      end
    end
    idle_inputs();
    run_cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    preload();
    test_write_read();
    test_round_robin();
    test_lock();
    test_own_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_arbiter

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 18, register data width; ADDR_W, 4, register index width (16 registers).
REQ-002 One clock; reset is asynchronous and active-high. Ports SHALL be clock (input, 1, rising-edge clock) and reset (input, 1, async active-high reset).
REQ-003 Per requester i in {0,1}, ports SHALL be: req_valid_i (input, 1, operation offered); req_ready_i (output, 1, operation granted this cycle); req_write_i (input, 1, 1 = write, 0 = read); req_lock_i (input, 1, retain ownership after this grant).
REQ-004 Per requester i, ports SHALL also be: req_addr_a_i (input, ADDR_W, write index or read index 1); req_addr_b_i (input, ADDR_W, read index 2); req_wdata_i (input, DATA_W, write data).
REQ-005 Per requester i, response ports SHALL be: rsp_valid_i (output, 1, read data valid); rsp_data_a_i and rsp_data_b_i (output, DATA_W each, read results).
REQ-006 Register-file side ports SHALL be: rf_enable, rf_load (output, 1 each); rf_reg_to_write, rf_reg_to_read1, rf_reg_to_read2 (output, ADDR_W each); rf_data_to_write (output, DATA_W); rf_data_to_read1, rf_data_to_read2 (input, DATA_W each).

Function
REQ-007 At most one operation SHALL be granted per cycle; req_ready_i SHALL be combinational and high only when requester i is granted; a transfer occurs when req_valid_i and req_ready_i are both high.
REQ-008 On a grant: rf_enable = 1; rf_load = req_write; rf_reg_to_write and rf_reg_to_read1 = req_addr_a; rf_reg_to_read2 = req_addr_b; rf_data_to_write = req_wdata. With no grant: all rf outputs SHALL be 0.
REQ-009 FSM states SHALL be SHARED, OWN0 and OWN1. In SHARED, a lone valid requester SHALL be granted; if both are valid, the requester named by the round-robin pointer SHALL win.
REQ-010 The round-robin pointer SHALL move to the other requester after every grant made in SHARED; it SHALL NOT change in OWN0 or OWN1.
REQ-011 A grant in SHARED with req_lock = 1 SHALL move the FSM to OWNi. In OWNi, only requester i SHALL be grantable; the other requester's ready SHALL stay 0 even when requester i is idle.
REQ-012 A grant in OWNi with req_lock = 0 SHALL return the FSM to SHARED on the next cycle.
REQ-013 A granted read in cycle N SHALL assert rsp_valid_i for exactly one cycle, N+1, for the granting requester only; the other requester's rsp_valid SHALL stay 0.
REQ-014 rsp_data_a_i and rsp_data_b_i SHALL pass rf_data_to_read1 and rf_data_to_read2 through unmodified; their value is defined only while rsp_valid_i = 1.
REQ-015 A granted write SHALL produce no response; writes SHALL be visible to reads granted in cycle N+1 or later.
REQ-016 Responses have no backpressure. Back-to-back reads SHALL produce back-to-back rsp_valid pulses.

Reset
REQ-017 While reset is high: FSM = SHARED, pointer = requester 0, rsp_valid_0 = rsp_valid_1 = 0, and all req_ready and rf outputs = 0.
REQ-018 Reset asserted mid-operation SHALL discard any pending response and any ownership; no rsp_valid SHALL follow reset deassertion until a new read is granted.
REQ-019 Register-file contents are not cleared by this block.

Structure
REQ-020 DATA_W, ADDR_W defaults and the FSM state enumeration SHALL live in shared package regfile_pkg.
REQ-021 Two-way round-robin pick logic (pointer plus grant vector) SHALL be a sub-module arb_rr2; the FSM and response pipeline register SHALL stay in regfile_arbiter.

Verification
REQ-022 Stimulus: reset, then requester 0 writes 18'h2A5A5 to reg 3, then reads a=3, b=3. Required: rsp_valid_0 one cycle after the read grant, both data = 18'h2A5A5.
REQ-023 Stimulus: both requesters assert read continuously from reset. Required: grants alternate 0, 1, 0, 1, and each rsp_valid pulse goes to the matching requester.
REQ-024 Stimulus: requester 1 makes three locked writes, then one unlocked write, while requester 0 stays valid. Required: four consecutive grants to 1, then requester 0 granted.
REQ-025 Stimulus: requester 0 in OWN0 deasserts req_valid for two cycles. Required: req_ready_1 = 0 throughout and rf_enable = 0.
REQ-026 Stimulus: reset asserted in the cycle after a read grant. Required: no rsp_valid, FSM = SHARED, pointer = 0.
REQ-027 Stimulus: write reg 5 = 1 in cycle N, read reg 5 in cycle N+1. Required: response data = 1.
